// File: rtl/rv32_register_file_if.sv
// Register-file access bundle: two combinational read ports and one write port.
// The core drives addresses and write data (master); the register file answers (slave).
interface rv32_register_file_if #(
    parameter int XLEN = 32
);
    logic        [4:0]      rs1;
    logic signed [XLEN-1:0] rd1;
    logic        [4:0]      rs2;
    logic signed [XLEN-1:0] rd2;
    logic        [4:0]      rd;
    logic        [XLEN-1:0] rd_wd;
    logic                   rd_we;

    modport master (
        output rs1, rs2, rd, rd_wd, rd_we,
        input  rd1, rd2
    );

    modport slave (
        input  rs1, rs2, rd, rd_wd, rd_we,
        output rd1, rd2
    );
endinterface

// File: rtl/rv32_register_file.sv
// RV32I/RV32E integer register file: x0 hardwired to zero, two asynchronous read
// ports, one write port committed on the rising clock edge, no write-to-read bypass.
module rv32_register_file #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    rv32_register_file_if.slave  bus
);
    localparam int ADDR_SPACE = 32;

    // x0 and addresses beyond NUM_REGS have no storage behind them
    function automatic logic addr_mapped(input logic [4:0] addr);
        return (addr != 5'd0) && (int'(addr) < NUM_REGS);
    endfunction

    logic [XLEN-1:0] regs_r [1:NUM_REGS-1];
    logic [XLEN-1:0] view_s [ADDR_SPACE];
    logic            wr_en_s;

    // Qualify the write: reset, enable, x0 and unmapped targets all suppress it
    always_comb begin
        wr_en_s = 1'b0;
        if (rst_n && bus.rd_we && addr_mapped(bus.rd)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage: asynchronous clear, single write port on the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_en_s && (bus.rd == 5'(i))) begin
                    regs_r[i] <= bus.rd_wd;
                end
            end
        end
    end

    // Full 5-bit address view; x0 and unmapped slots read as constant zero
    for (genvar g = 0; g < ADDR_SPACE; g++) begin : g_view
        if ((g == 0) || (g >= NUM_REGS)) begin : g_zero
            assign view_s[g] = '0;
        end else begin : g_reg
            assign view_s[g] = regs_r[g];
        end
    end

    // Asynchronous read ports, forced to zero while reset is held
    always_comb begin
        bus.rd1 = '0;
        bus.rd2 = '0;
        if (rst_n) begin
            bus.rd1 = view_s[bus.rs1];
            bus.rd2 = view_s[bus.rs2];
        end else begin
            bus.rd1 = '0;
            bus.rd2 = '0;
        end
    end
endmodule

// File: tb/tb_rv32_register_file.sv
// Self-checking bench for rv32_register_file: a 32-entry and a 16-entry instance
// driven in lockstep and compared against array-based reference models.
module tb_rv32_register_file;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] model32 [32];
    logic [31:0] model16 [32];

    rv32_register_file_if #(.XLEN(32)) bus32 ();
    rv32_register_file_if #(.XLEN(32)) bus16 ();

    rv32_register_file #(.XLEN(32), .NUM_REGS(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32.slave)
    );

    rv32_register_file #(.XLEN(32), .NUM_REGS(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref32(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'd0;
        return model32[a];
    endfunction

    function automatic logic [31:0] ref16(input logic [4:0] a);
        if (!rst_n || a == 5'd0 || a >= 5'd16) return 32'd0;
        return model16[a];
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 32; i++) begin
            model32[i] = 32'd0;
            model16[i] = 32'd0;
        end
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] wa,
                         input logic [31:0] wd, input logic we);
        bus32.rs1 = a1; bus32.rs2 = a2; bus32.rd = wa; bus32.rd_wd = wd; bus32.rd_we = we;
        bus16.rs1 = a1; bus16.rs2 = a2; bus16.rd = wa; bus16.rd_wd = wd; bus16.rd_we = we;
    endtask

    task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
        bus32.rs1 = a1; bus32.rs2 = a2;
        bus16.rs1 = a1; bus16.rs2 = a2;
    endtask

    // One rising edge; the models commit whatever write was presented at the edge
    task automatic tick();
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        @(posedge clk);
        we = bus32.rd_we; wa = bus32.rd; wd = bus32.rd_wd;
        if (rst_n && we && wa != 5'd0) model32[wa] = wd;
        if (rst_n && we && wa != 5'd0 && wa < 5'd16) model16[wa] = wd;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_models();
        drive(5'd5, 5'd9, 5'd5, 32'hDEADBEEF, 1'b1);
        #2;
        checks++;
        if (bus32.rd1 !== 32'd0 || bus32.rd2 !== 32'd0) begin
            failures++;
            $display("FAIL reset_initial rd1=%h rd2=%h expected 0", bus32.rd1, bus32.rd2);
        end
        tick();
        checks++;
        if (bus32.rd1 !== 32'd0) begin
            failures++;
            $display("FAIL write_in_reset rd1=%h expected 0", bus32.rd1);
        end
        rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (bus32.rd1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_x5 rd1=%h expected deadbeef", bus32.rd1);
        end
        // mid-cycle reset pulse, no clock edge required
        #2;
        rst_n = 1'b0;
        clear_models();
        #1;
        checks++;
        if (bus32.rd1 !== 32'd0 || bus16.rd1 !== 32'd0) begin
            failures++;
            $display("FAIL async_reset rd1=%h rd1_16=%h expected 0", bus32.rd1, bus16.rd1);
        end
        // pending write held through an edge under reset does not land
        drive(5'd6, 5'd5, 5'd6, 32'h0BADF00D, 1'b1);
        tick();
        drive(5'd6, 5'd5, 5'd0, 32'd0, 1'b0);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus32.rd1 !== 32'd0 || bus32.rd2 !== 32'd0) begin
            failures++;
            $display("FAIL reset_pending_write rd1=%h rd2=%h expected 0", bus32.rd1, bus32.rd2);
        end
    endtask

    task automatic test_basic();
        drive(5'd3, 5'd3, 5'd3, 32'h12345678, 1'b1);
        tick();
        drive(5'd3, 5'd3, 5'd0, 32'd0, 1'b0);
        #1;
        checks++;
        if (bus32.rd1 !== 32'h12345678 || bus32.rd2 !== 32'h12345678) begin
            failures++;
            $display("FAIL basic_rw rd1=%h rd2=%h expected 12345678", bus32.rd1, bus32.rd2);
        end
    endtask

    task automatic test_x0();
        drive(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
        tick();
        #1;
        checks++;
        if (bus32.rd1 !== 32'd0 || bus32.rd2 !== 32'd0 || bus16.rd1 !== 32'd0) begin
            failures++;
            $display("FAIL x0_hardwired rd1=%h rd2=%h rd1_16=%h expected 0", bus32.rd1, bus32.rd2, bus16.rd1);
        end
        drive(5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic test_we_bypass();
        drive(5'd7, 5'd7, 5'd7, 32'h00000011, 1'b1);
        tick();
        drive(5'd7, 5'd7, 5'd7, 32'h00000022, 1'b0);
        tick();
        checks++;
        if (bus32.rd1 !== 32'h00000011) begin
            failures++;
            $display("FAIL we_gating rd1=%h expected 00000011", bus32.rd1);
        end
        bus32.rd_we = 1'b1; bus16.rd_we = 1'b1;
        #1;
        checks++;
        if (bus32.rd1 !== 32'h00000011 || bus16.rd1 !== 32'h00000011) begin
            failures++;
            $display("FAIL no_bypass rd1=%h rd1_16=%h expected 00000011", bus32.rd1, bus16.rd1);
        end
        tick();
        checks++;
        if (bus32.rd1 !== 32'h00000022 || bus16.rd1 !== 32'h00000022) begin
            failures++;
            $display("FAIL post_edge rd1=%h rd1_16=%h expected 00000022", bus32.rd1, bus16.rd1);
        end
        drive(5'd7, 5'd7, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] last;
        last = 32'd0;
        for (int i = 0; i < 4; i++) begin
            last = $urandom;
            drive(5'd9, 5'd9, 5'd9, last, 1'b1);
            tick();
        end
        drive(5'd9, 5'd9, 5'd0, 32'd0, 1'b0);
        #1;
        checks++;
        if (bus32.rd1 !== last || bus32.rd2 !== ref32(5'd9)) begin
            failures++;
            $display("FAIL back_to_back rd1=%h rd2=%h expected %h", bus32.rd1, bus32.rd2, last);
        end
    endtask

    task automatic test_sweep();
        int bad;
        for (int i = 1; i < 32; i++) begin
            drive(5'd0, 5'd0, 5'(i), 32'(i) * 32'h01010101, 1'b1);
            tick();
        end
        drive(5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            set_reads(5'(i), 5'(31 - i));
            #1;
            checks++;
            if (bus32.rd1 !== (32'(i) * 32'h01010101) ||
                bus32.rd2 !== (32'(31 - i) * 32'h01010101) ||
                bus16.rd1 !== ref16(5'(i)) || bus16.rd2 !== ref16(5'(31 - i))) begin
                failures++;
                $display("FAIL sweep i=%0d rd1=%h rd2=%h rd1_16=%h rd2_16=%h expected %h %h %h %h",
                         i, bus32.rd1, bus32.rd2, bus16.rd1, bus16.rd2,
                         32'(i) * 32'h01010101, 32'(31 - i) * 32'h01010101,
                         ref16(5'(i)), ref16(5'(31 - i)));
            end
        end
    endtask

    task automatic test_signed_and_range();
        drive(5'd1, 5'd4, 5'd1, 32'h80000000, 1'b1);
        tick();
        drive(5'd1, 5'd4, 5'd20, 32'd5, 1'b1);
        #1;
        checks++;
        if (bus32.rd1 !== 32'h80000000 || !($signed(bus32.rd1) < 0)) begin
            failures++;
            $display("FAIL signed_x1 rd1=%h expected 80000000 negative", bus32.rd1);
        end
        tick();
        drive(5'd20, 5'd4, 5'd0, 32'd0, 1'b0);
        #1;
        checks++;
        if (bus16.rd1 !== 32'd0 || bus16.rd2 !== 32'h04040404) begin
            failures++;
            $display("FAIL rv32e_range rd1_16=%h rd2_16=%h expected 0 04040404", bus16.rd1, bus16.rd2);
        end
        checks++;
        if (bus32.rd1 !== 32'd5) begin
            failures++;
            $display("FAIL rv32i_x20 rd1=%h expected 5", bus32.rd1);
        end
    endtask

    task automatic test_random();
        logic [4:0]  a1, a2, wa;
        logic [31:0] wd;
        logic        we;
        for (int n = 0; n < 300; n++) begin
            a1 = 5'($urandom_range(31)); a2 = 5'($urandom_range(31));
            wa = 5'($urandom_range(31)); wd = $urandom; we = 1'($urandom_range(1));
            drive(a1, a2, wa, wd, we);
            #1;
            checks++;
            if (bus32.rd1 !== ref32(a1) || bus32.rd2 !== ref32(a2) ||
                bus16.rd1 !== ref16(a1) || bus16.rd2 !== ref16(a2)) begin
                failures++;
                $display("FAIL random_pre n=%0d rs=%0d/%0d got %h %h %h %h expected %h %h %h %h",
                         n, a1, a2, bus32.rd1, bus32.rd2, bus16.rd1, bus16.rd2,
                         ref32(a1), ref32(a2), ref16(a1), ref16(a2));
            end
            tick();
            checks++;
            if (bus32.rd1 !== ref32(a1) || bus32.rd2 !== ref32(a2) ||
                bus16.rd1 !== ref16(a1) || bus16.rd2 !== ref16(a2)) begin
                failures++;
                $display("FAIL random_post n=%0d rs=%0d/%0d got %h %h %h %h expected %h %h %h %h",
                         n, a1, a2, bus32.rd1, bus32.rd2, bus16.rd1, bus16.rd2,
                         ref32(a1), ref32(a2), ref16(a1), ref16(a2));
            end
        end
        drive(5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_x0();
        test_we_bypass();
        test_back_to_back();
        test_sweep();
        test_signed_and_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
